// File: rtl/dmem_arbiter_pkg.sv
// Shared types and constants for the two-port data-memory arbiter.
package dmem_arbiter_pkg;

  localparam int DMEM_NPORTS = 2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOCKED0 = 2'd1,
    LOCKED1 = 2'd2
  } dmem_arb_state_t;

  function automatic logic is_aligned(input logic [1:0] byte_off);
    return byte_off == 2'b00;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Combinational two-way round-robin grant; a lock restricts the grant to its owner.
module rr_arb2
  import dmem_arbiter_pkg::*;
(
  input  logic [DMEM_NPORTS-1:0] valid_i,
  input  logic                   last_gnt_i,
  input  dmem_arb_state_t        state_i,
  output logic [DMEM_NPORTS-1:0] gnt_o
);

  always_comb begin
    gnt_o = '0;
    case (state_i)
      LOCKED0: gnt_o[0] = valid_i[0];
      LOCKED1: gnt_o[1] = valid_i[1];
      default: begin
        // On a tie the port that did not win last time goes first.
        if (&valid_i) gnt_o = last_gnt_i ? 2'b01 : 2'b10;
        else          gnt_o = valid_i;
      end
    endcase
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of the word-addressed data memory (port 0: MEM stage,
// port 1: debug/DMA loader); one grant per cycle, registered one-cycle response.
//   state   | meaning
//   IDLE    | round-robin between both ports
//   LOCKED0 | port 0 holds the memory for an atomic sequence
//   LOCKED1 | port 1 holds the memory for an atomic sequence
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,

  input  logic                  req0_valid_i,
  output logic                  req0_ready_o,
  input  logic                  req0_we_i,
  input  logic                  req0_lock_i,
  input  logic [ADDR_WIDTH-1:0] req0_addr_i,
  input  logic [DATA_WIDTH-1:0] req0_wdata_i,
  output logic                  rsp0_valid_o,
  output logic [DATA_WIDTH-1:0] rsp0_rdata_o,
  output logic                  rsp0_err_o,

  input  logic                  req1_valid_i,
  output logic                  req1_ready_o,
  input  logic                  req1_we_i,
  input  logic                  req1_lock_i,
  input  logic [ADDR_WIDTH-1:0] req1_addr_i,
  input  logic [DATA_WIDTH-1:0] req1_wdata_i,
  output logic                  rsp1_valid_o,
  output logic [DATA_WIDTH-1:0] rsp1_rdata_o,
  output logic                  rsp1_err_o,

  output logic                  mem_we_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i
);

  dmem_arb_state_t              state_q, state_d;
  logic                         last_gnt_q, last_gnt_d;
  logic [DMEM_NPORTS-1:0]       gnt, xfer;
  logic                         win, any_xfer, sel_we, sel_lock, aligned;
  logic [DATA_WIDTH-1:0]        rdata;
  logic [DMEM_NPORTS-1:0]       rsp_valid_q, rsp_valid_d;
  logic [DMEM_NPORTS-1:0]       rsp_err_q, rsp_err_d;
  logic [DATA_WIDTH-1:0]        rsp0_rdata_q, rsp0_rdata_d;
  logic [DATA_WIDTH-1:0]        rsp1_rdata_q, rsp1_rdata_d;

  rr_arb2 u_rr_arb2 (
    .valid_i    ({req1_valid_i, req0_valid_i}),
    .last_gnt_i (last_gnt_q),
    .state_i    (state_q),
    .gnt_o      (gnt)
  );

  // Nothing is accepted while reset is held, so no write can land in a reset cycle.
  assign xfer         = rst_i ? '0 : gnt;
  assign any_xfer     = |xfer;
  assign win          = xfer[1];
  assign req0_ready_o = xfer[0];
  assign req1_ready_o = xfer[1];

  assign mem_addr_o  = win ? req1_addr_i  : req0_addr_i;
  assign mem_wdata_o = win ? req1_wdata_i : req0_wdata_i;
  assign sel_we      = win ? req1_we_i    : req0_we_i;
  assign sel_lock    = win ? req1_lock_i  : req0_lock_i;
  assign aligned     = is_aligned(mem_addr_o[1:0]);
  assign mem_we_o    = any_xfer & sel_we & aligned;

  always_comb begin
    state_d    = state_q;
    last_gnt_d = last_gnt_q;
    if (any_xfer) begin
      last_gnt_d = win;
      case (state_q)
        IDLE:    if (sel_lock)  state_d = win ? LOCKED1 : LOCKED0;
        default: if (!sel_lock) state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    rdata        = (any_xfer && !sel_we && aligned) ? mem_rdata_i : '0;
    rsp_valid_d  = xfer;
    rsp_err_d    = xfer & {DMEM_NPORTS{~aligned}};
    rsp0_rdata_d = xfer[0] ? rdata : '0;
    rsp1_rdata_d = xfer[1] ? rdata : '0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      last_gnt_q   <= 1'b1;
      rsp_valid_q  <= '0;
      rsp_err_q    <= '0;
      rsp0_rdata_q <= '0;
      rsp1_rdata_q <= '0;
    end else begin
      state_q      <= state_d;
      last_gnt_q   <= last_gnt_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_err_q    <= rsp_err_d;
      rsp0_rdata_q <= rsp0_rdata_d;
      rsp1_rdata_q <= rsp1_rdata_d;
    end
  end

  assign rsp0_valid_o = rsp_valid_q[0];
  assign rsp1_valid_o = rsp_valid_q[1];
  assign rsp0_err_o   = rsp_err_q[0];
  assign rsp1_err_o   = rsp_err_q[1];
  assign rsp0_rdata_o = rsp0_rdata_q;
  assign rsp1_rdata_o = rsp1_rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios plus a randomized run against a
// transaction-level model (lock owner, last winner, word array).
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req0_ready, req0_we, req0_lock;
  logic [31:0] req0_addr, req0_wdata;
  logic        rsp0_valid, rsp0_err;
  logic [31:0] rsp0_rdata;
  logic        req1_valid, req1_ready, req1_we, req1_lock;
  logic [31:0] req1_addr, req1_wdata;
  logic        rsp1_valid, rsp1_err;
  logic [31:0] rsp1_rdata;
  logic        mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  logic [31:0] mem     [0:255];
  logic [31:0] ref_mem [0:255];

  int n_checks = 0;
  int n_errors = 0;

  // Model state: lock owner (-1 = none) and last winner.
  int lock_owner = -1;
  int last_winner = 1;

  // Observed and expected values of the last step.
  logic        o_rdy0, o_rdy1, o_we, o_v0, o_e0, o_v1, o_e1;
  logic [31:0] o_addr, o_wdata, o_d0, o_d1;
  logic        x_rdy0, x_rdy1, x_we, x_v0, x_e0, x_v1, x_e1;
  logic [31:0] x_addr, x_wdata, x_d0, x_d1;

  always #5 clk = ~clk;

  dmem_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) dut (
    .clk_i(clk), .rst_i(rst),
    .req0_valid_i(req0_valid), .req0_ready_o(req0_ready), .req0_we_i(req0_we),
    .req0_lock_i(req0_lock), .req0_addr_i(req0_addr), .req0_wdata_i(req0_wdata),
    .rsp0_valid_o(rsp0_valid), .rsp0_rdata_o(rsp0_rdata), .rsp0_err_o(rsp0_err),
    .req1_valid_i(req1_valid), .req1_ready_o(req1_ready), .req1_we_i(req1_we),
    .req1_lock_i(req1_lock), .req1_addr_i(req1_addr), .req1_wdata_i(req1_wdata),
    .rsp1_valid_o(rsp1_valid), .rsp1_rdata_o(rsp1_rdata), .rsp1_err_o(rsp1_err),
    .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
    .mem_rdata_i(mem_rdata)
  );

  assign mem_rdata = mem[mem_addr[9:2]];
  always @(posedge clk) if (mem_we) mem[mem_addr[9:2]] <= mem_wdata;

  // One clock cycle: drive at negedge, sample combinational outputs, then
  // sample the registered response after the posedge and advance the model.
  task automatic step(input logic r,
                      input logic v0, input logic w0, input logic l0,
                      input logic [31:0] a0, input logic [31:0] d0,
                      input logic v1, input logic w1, input logic l1,
                      input logic [31:0] a1, input logic [31:0] d1);
    int g;
    logic [31:0] ga, gd;
    logic gw, gl, al;
    @(negedge clk);
    rst = r;
    req0_valid = v0; req0_we = w0; req0_lock = l0; req0_addr = a0; req0_wdata = d0;
    req1_valid = v1; req1_we = w1; req1_lock = l1; req1_addr = a1; req1_wdata = d1;
    #1;
    g = -1;
    if (!r) begin
      if (lock_owner == 0)      g = v0 ? 0 : -1;
      else if (lock_owner == 1) g = v1 ? 1 : -1;
      else if (v0 && v1)        g = 1 - last_winner;
      else if (v0)              g = 0;
      else if (v1)              g = 1;
    end
    ga = (g == 1) ? a1 : a0;
    gd = (g == 1) ? d1 : d0;
    gw = (g == 1) ? w1 : w0;
    gl = (g == 1) ? l1 : l0;
    al = (ga[1:0] == 2'b00);
    x_rdy0 = (g == 0); x_rdy1 = (g == 1);
    x_we = (g >= 0) && gw && al;
    x_addr = ga; x_wdata = gd;
    o_rdy0 = req0_ready; o_rdy1 = req1_ready; o_we = mem_we;
    o_addr = mem_addr; o_wdata = mem_wdata;
    x_v0 = (g == 0); x_v1 = (g == 1);
    x_e0 = (g == 0) && !al; x_e1 = (g == 1) && !al;
    x_d0 = (g == 0 && !gw && al) ? ref_mem[ga[9:2]] : 32'h0;
    x_d1 = (g == 1 && !gw && al) ? ref_mem[ga[9:2]] : 32'h0;
    @(posedge clk);
    #1;
    o_v0 = rsp0_valid; o_e0 = rsp0_err; o_d0 = rsp0_rdata;
    o_v1 = rsp1_valid; o_e1 = rsp1_err; o_d1 = rsp1_rdata;
    if (r) begin
      lock_owner = -1;
      last_winner = 1;
    end else if (g >= 0) begin
      if (gw && al) ref_mem[ga[9:2]] = gd;
      last_winner = g;
      lock_owner = gl ? g : -1;
    end
  endtask

  task automatic idle_step();
    step(0, 0,0,0,32'h0,32'h0, 0,0,0,32'h0,32'h0);
  endtask

  task automatic test_reset();
    for (int i = 0; i < 256; i++) begin
      mem[i] = $urandom;
      ref_mem[i] = mem[i];
    end
    mem[4] = 32'hDEADBEEF; ref_mem[4] = 32'hDEADBEEF;
    step(1, 1,1,0,32'h10,32'h11, 1,1,0,32'h20,32'h22);
    n_checks++;
    if ({o_rdy0, o_rdy1, o_we} !== 3'b000) begin
      n_errors++; $display("FAIL reset_ready_we: got %b expected 000", {o_rdy0, o_rdy1, o_we});
    end
    n_checks++;
    if ({o_v0, o_e0, o_v1, o_e1, o_d0, o_d1} !== 68'h0) begin
      n_errors++; $display("FAIL reset_rsp: got v0=%b e0=%b v1=%b e1=%b d0=%h d1=%h expected all 0",
                           o_v0, o_e0, o_v1, o_e1, o_d0, o_d1);
    end
    // Reset must not have written the memory.
    n_checks++;
    if (mem[4] !== 32'hDEADBEEF || mem[8] !== ref_mem[8]) begin
      n_errors++; $display("FAIL reset_no_write: mem[4]=%h mem[8]=%h expected %h %h",
                           mem[4], mem[8], 32'hDEADBEEF, ref_mem[8]);
    end
  endtask

  task automatic test_first_read();
    step(0, 1,0,0,32'h10,32'h0, 0,0,0,32'h0,32'h0);
    n_checks++;
    if (o_rdy0 !== 1'b1) begin
      n_errors++; $display("FAIL first_ready0: got %b expected 1", o_rdy0);
    end
    n_checks++;
    if (o_v0 !== 1'b1 || o_d0 !== 32'hDEADBEEF || o_v1 !== 1'b0) begin
      n_errors++; $display("FAIL first_rsp: got v0=%b d0=%h v1=%b expected 1 deadbeef 0", o_v0, o_d0, o_v1);
    end
  endtask

  task automatic test_round_robin();
    step(1, 0,0,0,32'h0,32'h0, 0,0,0,32'h0,32'h0);
    for (int i = 0; i < 4; i++) begin
      step(0, 1,0,0,32'h100 + 32'(i*4),32'h0, 1,0,0,32'h200 + 32'(i*4),32'h0);
      n_checks++;
      if ({o_rdy1, o_rdy0} !== ((i % 2 == 0) ? 2'b01 : 2'b10)) begin
        n_errors++; $display("FAIL rr_grant[%0d]: got %b expected %b", i, {o_rdy1, o_rdy0},
                             (i % 2 == 0) ? 2'b01 : 2'b10);
      end
      n_checks++;
      if ({o_v1, o_v0} !== ((i % 2 == 0) ? 2'b01 : 2'b10) || o_d0 !== x_d0 || o_d1 !== x_d1) begin
        n_errors++; $display("FAIL rr_rsp[%0d]: got v=%b d0=%h d1=%h expected d0=%h d1=%h",
                             i, {o_v1, o_v0}, o_d0, o_d1, x_d0, x_d1);
      end
    end
  endtask

  task automatic test_lock();
    step(0, 0,0,0,32'h0,32'h0, 1,1,1,32'h20,32'hAA);
    n_checks++;
    if (o_rdy1 !== 1'b1 || o_we !== 1'b1) begin
      n_errors++; $display("FAIL lock_write: got ready1=%b we=%b expected 1 1", o_rdy1, o_we);
    end
    for (int i = 0; i < 3; i++) begin
      step(0, 1,0,0,32'h30,32'h0, 0,0,0,32'h0,32'h0);
      n_checks++;
      if (o_rdy0 !== 1'b0 || o_v0 !== 1'b0) begin
        n_errors++; $display("FAIL lock_block[%0d]: got ready0=%b rsp0_valid=%b expected 0 0", i, o_rdy0, o_v0);
      end
    end
    step(0, 1,0,0,32'h30,32'h0, 1,0,0,32'h20,32'h0);
    n_checks++;
    if (o_rdy1 !== 1'b1 || o_rdy0 !== 1'b0 || o_d1 !== 32'hAA) begin
      n_errors++; $display("FAIL lock_release: got ready1=%b ready0=%b rdata1=%h expected 1 0 aa",
                           o_rdy1, o_rdy0, o_d1);
    end
    step(0, 1,0,0,32'h30,32'h0, 0,0,0,32'h0,32'h0);
    n_checks++;
    if (o_rdy0 !== 1'b1) begin
      n_errors++; $display("FAIL lock_after: got ready0=%b expected 1", o_rdy0);
    end
  endtask

  task automatic test_misaligned();
    step(0, 1,1,0,32'h22,32'h1234, 0,0,0,32'h0,32'h0);
    n_checks++;
    if (o_we !== 1'b0 || o_v0 !== 1'b1 || o_e0 !== 1'b1 || o_d0 !== 32'h0) begin
      n_errors++; $display("FAIL misaligned_wr: got we=%b v0=%b err0=%b d0=%h expected 0 1 1 0",
                           o_we, o_v0, o_e0, o_d0);
    end
    step(0, 1,0,0,32'h20,32'h0, 0,0,0,32'h0,32'h0);
    n_checks++;
    if (o_d0 !== 32'hAA || o_e0 !== 1'b0) begin
      n_errors++; $display("FAIL misaligned_old: got d0=%h err0=%b expected aa 0", o_d0, o_e0);
    end
  endtask

  task automatic test_reset_midlock();
    step(1, 0,0,0,32'h0,32'h0, 0,0,0,32'h0,32'h0);
    step(0, 1,0,1,32'h10,32'h0, 0,0,0,32'h0,32'h0);
    n_checks++;
    if (o_rdy0 !== 1'b1 || o_v0 !== 1'b1) begin
      n_errors++; $display("FAIL midlock_grant: got ready0=%b v0=%b expected 1 1", o_rdy0, o_v0);
    end
    step(1, 1,1,0,32'h10,32'h99, 0,0,0,32'h0,32'h0);
    n_checks++;
    if (o_rdy0 !== 1'b0 || o_we !== 1'b0 || o_v0 !== 1'b0) begin
      n_errors++; $display("FAIL midlock_rst: got ready0=%b we=%b v0=%b expected 0 0 0", o_rdy0, o_we, o_v0);
    end
    step(0, 1,0,0,32'h14,32'h0, 1,0,0,32'h18,32'h0);
    n_checks++;
    if ({o_rdy1, o_rdy0} !== 2'b01) begin
      n_errors++; $display("FAIL midlock_tie: got %b expected 01", {o_rdy1, o_rdy0});
    end
  endtask

  task automatic test_back_to_back();
    step(0, 1,1,0,32'h40,32'h5, 0,0,0,32'h0,32'h0);
    n_checks++;
    if (o_we !== 1'b1 || o_v0 !== 1'b1) begin
      n_errors++; $display("FAIL b2b_write: got we=%b v0=%b expected 1 1", o_we, o_v0);
    end
    step(0, 1,0,0,32'h40,32'h0, 0,0,0,32'h0,32'h0);
    n_checks++;
    if (o_v0 !== 1'b1 || o_d0 !== 32'h5) begin
      n_errors++; $display("FAIL b2b_read: got v0=%b d0=%h expected 1 5", o_v0, o_d0);
    end
    idle_step();
    n_checks++;
    if (o_v0 !== 1'b0 || o_v1 !== 1'b0) begin
      n_errors++; $display("FAIL b2b_pulse_end: got v0=%b v1=%b expected 0 0", o_v0, o_v1);
    end
  endtask

  task automatic test_random();
    logic [31:0] a0, a1;
    for (int i = 0; i < 600; i++) begin
      a0 = 32'($urandom_range(0, 1023));
      a1 = 32'($urandom_range(0, 1023));
      if ($urandom_range(0, 3) != 0) a0[1:0] = 2'b00;
      if ($urandom_range(0, 3) != 0) a1[1:0] = 2'b00;
      step(($urandom_range(0, 49) == 0),
           1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 1)),
           ($urandom_range(0, 3) == 0), a0, $urandom,
           1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 1)),
           ($urandom_range(0, 3) == 0), a1, $urandom);
      n_checks++;
      if ({o_rdy0, o_rdy1, o_we} !== {x_rdy0, x_rdy1, x_we} ||
          o_addr !== x_addr || o_wdata !== x_wdata) begin
        n_errors++; $display("FAIL rand_req[%0d]: got rdy=%b%b we=%b addr=%h wd=%h expected rdy=%b%b we=%b addr=%h wd=%h",
                             i, o_rdy0, o_rdy1, o_we, o_addr, o_wdata, x_rdy0, x_rdy1, x_we, x_addr, x_wdata);
      end
      n_checks++;
      if ({o_v0, o_e0, o_v1, o_e1} !== {x_v0, x_e0, x_v1, x_e1} || o_d0 !== x_d0 || o_d1 !== x_d1) begin
        n_errors++; $display("FAIL rand_rsp[%0d]: got v/e=%b%b%b%b d0=%h d1=%h expected v/e=%b%b%b%b d0=%h d1=%h",
                             i, o_v0, o_e0, o_v1, o_e1, o_d0, o_d1, x_v0, x_e0, x_v1, x_e1, x_d0, x_d1);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    req0_valid = 0; req0_we = 0; req0_lock = 0; req0_addr = '0; req0_wdata = '0;
    req1_valid = 0; req1_we = 0; req1_lock = 0; req1_addr = '0; req1_wdata = '0;
    test_reset();
    test_first_read();
    test_round_robin();
    test_lock();
    test_misaligned();
    test_reset_midlock();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
